// File: rtl/output_channel_buffer_bank_pkg.sv
// Shared sizing constants for the PE write-back output channel buffers.
package output_channel_buffer_bank_pkg;

    localparam int TIA_NUM_OUTPUT_CHANNELS        = 4;
    localparam int TIA_WORD_WIDTH                 = 32;
    localparam int TIA_TAG_WIDTH                  = 2;
    localparam int TIA_CHANNEL_BUFFER_FIFO_DEPTH  = 4;
    localparam int TIA_CHANNEL_BUFFER_COUNT_WIDTH = 3;

    typedef struct packed {
        logic [TIA_TAG_WIDTH-1:0]  tag;
        logic [TIA_WORD_WIDTH-1:0] data;
    } tagged_word_t;

endpackage

// File: rtl/output_channel_buffer_bank_fifo.sv
// Single-channel tagged FIFO with registered occupancy and a sticky overflow flag.
module output_channel_buffer_bank_fifo
    import output_channel_buffer_bank_pkg::*;
#(
    parameter int WORD_WIDTH  = TIA_WORD_WIDTH,
    parameter int TAG_WIDTH   = TIA_TAG_WIDTH,
    parameter int DEPTH       = TIA_CHANNEL_BUFFER_FIFO_DEPTH,
    parameter int COUNT_WIDTH = TIA_CHANNEL_BUFFER_COUNT_WIDTH
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enqueue,
    input  logic [TAG_WIDTH-1:0]   enqueue_tag,
    input  logic [WORD_WIDTH-1:0]  enqueue_data,
    output logic                   valid,
    output logic [TAG_WIDTH-1:0]   tag,
    output logic [WORD_WIDTH-1:0]  data,
    input  logic                   ready,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow_error
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int ENTRY_WIDTH = TAG_WIDTH + WORD_WIDTH;

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]   rptr;
    logic [PTR_WIDTH-1:0]   wptr;
    logic                   full;
    logic                   deq;
    logic                   enq;

    assign valid = (count != '0);
    assign full  = (count == COUNT_WIDTH'(DEPTH));
    assign deq   = valid & ready;
    // A pop in the same cycle frees the slot, so a full channel still accepts.
    assign enq   = enqueue & (~full | deq);

    always_comb begin
        tag  = '0;
        data = '0;
        if (valid) begin
            {tag, data} = mem[rptr];
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wptr] <= {enqueue_tag, enqueue_data};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr           <= '0;
            wptr           <= '0;
            count          <= '0;
            overflow_error <= 1'b0;
        end else begin
            if (enq) begin
                wptr <= wptr + PTR_WIDTH'(1);
            end
            if (deq) begin
                rptr <= rptr + PTR_WIDTH'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
            if (enqueue && full && !deq) begin
                overflow_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_channel_buffer_bank.sv
// Bank of independent output channel FIFOs fed by the write-back OCI mask (multicast capable).
module output_channel_buffer_bank
    import output_channel_buffer_bank_pkg::*;
#(
    parameter int NUM_CHANNELS = TIA_NUM_OUTPUT_CHANNELS,
    parameter int WORD_WIDTH   = TIA_WORD_WIDTH,
    parameter int TAG_WIDTH    = TIA_TAG_WIDTH,
    parameter int DEPTH        = TIA_CHANNEL_BUFFER_FIFO_DEPTH,
    parameter int COUNT_WIDTH  = TIA_CHANNEL_BUFFER_COUNT_WIDTH
)
(
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             enqueue_oci,
    input  logic [TAG_WIDTH-1:0]                enqueue_tag,
    input  logic [WORD_WIDTH-1:0]               enqueue_data,
    output logic [NUM_CHANNELS-1:0]             output_channel_valid,
    output logic [NUM_CHANNELS*TAG_WIDTH-1:0]   output_channel_tags,
    output logic [NUM_CHANNELS*WORD_WIDTH-1:0]  output_channel_data,
    input  logic [NUM_CHANNELS-1:0]             output_channel_ready,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] output_channel_counts,
    output logic [NUM_CHANNELS-1:0]             overflow_error
);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
        output_channel_buffer_bank_fifo #(
            .WORD_WIDTH  (WORD_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH),
            .DEPTH       (DEPTH),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_fifo (
            .clock          (clock),
            .reset          (reset),
            .enqueue        (enqueue_oci[i]),
            .enqueue_tag    (enqueue_tag),
            .enqueue_data   (enqueue_data),
            .valid          (output_channel_valid[i]),
            .tag            (output_channel_tags[i*TAG_WIDTH +: TAG_WIDTH]),
            .data           (output_channel_data[i*WORD_WIDTH +: WORD_WIDTH]),
            .ready          (output_channel_ready[i]),
            .count          (output_channel_counts[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .overflow_error (overflow_error[i])
        );
    end

endmodule

// File: doc/output_channel_buffer_bank.md
Name: output_channel_buffer_bank

Overview:
Bank of per-output-channel FIFOs at the PE's write-back end. Retiring instructions enqueue a tagged word into every channel selected by their one-hot/multicast OCI. The interconnect drains each channel via valid/ready. Exports exact per-channel occupancy counts, which the scheduler's full-status updater combines with in-flight OCIs to predict fullness.

Parameters:
NUM_CHANNELS, TIA_NUM_OUTPUT_CHANNELS (4), number of output channels
WORD_WIDTH, TIA_WORD_WIDTH (32), data word width
TAG_WIDTH, TIA_TAG_WIDTH (2), channel tag width
DEPTH, TIA_CHANNEL_BUFFER_FIFO_DEPTH (4), entries per channel; power of two, >= 2
COUNT_WIDTH, TIA_CHANNEL_BUFFER_COUNT_WIDTH (3), width of occupancy count; holds 0..DEPTH

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
enqueue_oci  in  NUM_CHANNELS  write-back channel mask; bit i set = enqueue into channel i this cycle
enqueue_tag  in  TAG_WIDTH  tag written to all selected channels
enqueue_data  in  WORD_WIDTH  word written to all selected channels
output_channel_valid  out  NUM_CHANNELS  channel i head entry is valid
output_channel_tags  out  TAG_WIDTH x NUM_CHANNELS  head tag per channel
output_channel_data  out  WORD_WIDTH x NUM_CHANNELS  head word per channel
output_channel_ready  in  NUM_CHANNELS  downstream accepts channel i head
output_channel_counts  out  COUNT_WIDTH x NUM_CHANNELS  registered occupancy per channel
overflow_error  out  NUM_CHANNELS  sticky; enqueue attempted into full channel without simultaneous dequeue

Behaviour:
- Reset (reset==0, async): all counts 0, read/write pointers 0, valid 0, overflow_error 0. Storage contents don't care. Tag/data outputs are 0 while valid is 0.
- Channels are independent. Per channel i per rising edge:
  - deq = valid[i] & ready[i]
  - enq = enqueue_oci[i] & (count<DEPTH | deq)
- enq writes {tag,data} at wptr, then wptr = wptr+1 mod DEPTH.
- deq advances rptr, then rptr = rptr+1 mod DEPTH.
- Count update: count += enq - deq. Both enq and deq in the same cycle leave count unchanged; this is legal at count==DEPTH and at count==1.
- Enqueue to empty: no bypass. Entry visible (valid=1) the cycle after the enqueue edge; 1-cycle latency.
- valid[i] = (count!=0), derived from the registered count. Head tag/data driven combinationally from storage at rptr.
- ready while valid=0 is ignored; no pop, no underflow.
- enqueue_oci[i] at count==DEPTH without deq: write dropped; pointers and count unchanged; overflow_error[i] set to 1 and held until reset. This indicates a scheduler bug.
- Multicast: multiple OCI bits set write the same tag/data into each selected channel in the same cycle. Overflow is evaluated per channel; other channels still accept.
- Counts are registered outputs only, with no combinational path from enqueue_oci or ready. The consumer adds in-flight instructions separately.
- Reset asserted mid-operation clears state immediately. Data in flight is lost.

Decomposition:
- TIA_* constants above live in the shared control/constants header. No new typedefs are required.
- Optional shared typedef: tagged-word struct {tag, data}.
- One natural sub-module: output_channel_buffer, a single-channel tagged FIFO with count and sticky overflow. The bank is NUM_CHANNELS instances plus port fan-out.

Test Plan:
- Reset: drive reset=0 mid-stream after 3 enqueues -> counts=0, valid=0, overflow_error=0 immediately (asynchronously); after release, first enqueue appears 1 cycle later.
- Fill/drain ch0: ready=0, enqueue 4 words 0x10..0x13 tags 0..3 -> count 1,2,3,4. Then ready=1 -> head sequence 0x10..0x13 in order, count 3,2,1,0, valid drops after the last word.
- Full + simultaneous: ch1 at count=4 with enqueue and ready both high -> 0x99 accepted, count stays 4, overflow_error[1]=0; 0x99 emerges after the 4 older words.
- Overflow: ch2 at count=4, ready=0, enqueue 0xAA -> count stays 4, overflow_error[2]=1 and sticky; drained contents exclude 0xAA.
- Multicast: enqueue_oci=4'b1011, data 0x55, tag 2 -> channels 0,1,3 each count+1 with head 0x55/2; ch2 unchanged.
- Wrap-around: 10 cycles of enqueue with ready=1 on ch3 -> pointers wrap past DEPTH and data matches a scoreboard in order. Random ready back-pressure over 1000 cycles -> count never exceeds 4 and matches the reference model every cycle.
